// File: rtl/system_state_pkg.sv
// Shared system-state encodings, also consumed by the LED controller.
package system_state_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'b00,
    ST_NORMAL  = 2'b01,
    ST_WARNING = 2'b10,
    ST_FAULT   = 2'b11
  } sys_state_e;

endpackage : system_state_pkg

// File: rtl/system_state_fsm_if.sv
// Condition/request inputs and status outputs of the supervisory FSM.
interface system_state_fsm_if #(
  parameter int unsigned FAULT_CNT_W = 8
);
  import system_state_pkg::*;

  logic                   enable;
  logic                   warn_cond;
  logic                   fault_cond;
  logic                   fault_clear;
  logic [STATE_W-1:0]     system_state;
  logic                   state_changed;
  logic [FAULT_CNT_W-1:0] fault_count;

  // Condition sources / requesters drive the inputs.
  modport master (
    output enable, warn_cond, fault_cond, fault_clear,
    input  system_state, state_changed, fault_count
  );

  // The FSM consumes the inputs and drives the status.
  modport slave (
    input  enable, warn_cond, fault_cond, fault_clear,
    output system_state, state_changed, fault_count
  );

endinterface : system_state_fsm_if

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
module debounce_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_async,
  output logic dout_filt
);

  // Counter only ever holds 0..DEBOUNCE_CYCLES-1.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Metastability synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din_async;
      sync2_q <= sync1_q;
    end
  end

  // Filtered value follows only after DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_filt = filt_q;

endmodule : debounce_filter

// File: rtl/system_state_fsm.sv
// Supervisory IDLE/NORMAL/WARNING/FAULT sequencer with warning hysteresis
// and a latched fault that needs an explicit clear.
module system_state_fsm
  import system_state_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RECOVER_CYCLES  = 16,
  parameter int unsigned FAULT_CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  system_state_fsm_if.slave  bus
);

  localparam int unsigned REC_W = $clog2(RECOVER_CYCLES);
  localparam logic [REC_W-1:0]       REC_LAST = REC_W'(RECOVER_CYCLES - 1);
  localparam logic [FAULT_CNT_W-1:0] FC_MAX   = '1;

  logic                   warn_f;
  logic                   fault_f;
  sys_state_e             state_q;
  sys_state_e             state_d;
  logic [REC_W-1:0]       rec_q;
  logic [REC_W-1:0]       rec_d;
  logic [FAULT_CNT_W-1:0] fc_q;
  logic [FAULT_CNT_W-1:0] fc_d;
  logic                   changed_q;
  logic                   changed_d;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_warn_filt (
    .clk       (clk),
    .reset     (reset),
    .din_async (bus.warn_cond),
    .dout_filt (warn_f)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_fault_filt (
    .clk       (clk),
    .reset     (reset),
    .din_async (bus.fault_cond),
    .dout_filt (fault_f)
  );

  // Next state, recovery hysteresis and fault-entry counting; fault > !enable > warning.
  always_comb begin
    state_d   = state_q;
    rec_d     = rec_q;
    fc_d      = fc_q;
    changed_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = fault_f ? ST_FAULT : ST_NORMAL;
        end
      end
      ST_NORMAL: begin
        if (fault_f) begin
          state_d = ST_FAULT;
        end else if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (warn_f) begin
          state_d = ST_WARNING;
        end
      end
      ST_WARNING: begin
        if (fault_f) begin
          state_d = ST_FAULT;
        end else if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (warn_f) begin
          rec_d = '0;
        end else if (rec_q == REC_LAST) begin
          state_d = ST_NORMAL;
        end else begin
          rec_d = rec_q + REC_W'(1);
        end
      end
      ST_FAULT: begin
        // A clear while the fault is still present is dropped, not remembered.
        if (bus.fault_clear && !fault_f) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Recovery count only lives inside WARNING.
    if (state_d != ST_WARNING) begin
      rec_d = '0;
    end

    if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && (fc_q != FC_MAX)) begin
      fc_d = fc_q + FAULT_CNT_W'(1);
    end

    changed_d = (state_d != state_q);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rec_q     <= '0;
      fc_q      <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_q     <= rec_d;
      fc_q      <= fc_d;
      changed_q <= changed_d;
    end
  end

  assign bus.system_state  = state_q;
  assign bus.state_changed = changed_q;
  assign bus.fault_count   = fc_q;

endmodule : system_state_fsm

// File: tb/tb_system_state_fsm.sv
// Directed plus randomized bench for system_state_fsm against a cycle-level
// reference model built from the behavioural rules.
module tb_system_state_fsm;

  localparam int DEB  = 4;
  localparam int REC  = 16;
  localparam int FCW  = 8;
  localparam int FMAX = (1 << FCW) - 1;

  logic clk;
  logic reset;

  system_state_fsm_if #(.FAULT_CNT_W(FCW)) bus ();

  system_state_fsm #(
    .DEBOUNCE_CYCLES (DEB),
    .RECOVER_CYCLES  (REC),
    .FAULT_CNT_W     (FCW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 IDLE, 1 NORMAL, 2 WARNING, 3 FAULT.
  int m_w_s1, m_w_s2, m_w_f, m_w_run;
  int m_f_s1, m_f_s2, m_f_f, m_f_run;
  int m_state, m_quiet, m_fc, m_chg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w_s1 = 0; m_w_s2 = 0; m_w_f = 0; m_w_run = 0;
    m_f_s1 = 0; m_f_s2 = 0; m_f_f = 0; m_f_run = 0;
    m_state = 0; m_quiet = 0; m_fc = 0; m_chg = 0;
  endtask

  // A filtered value flips once the synchronised input has disagreed with it
  // on DEB consecutive edges.
  task automatic debounce(input int s, inout int f, inout int run);
    if (s != f) begin
      run = run + 1;
      if (run == DEB) begin
        f   = s;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  // Advance the model by one clock edge using the input values at that edge.
  task automatic model_edge();
    int wf, ff, ns, nq;
    wf = m_w_f;
    ff = m_f_f;
    ns = m_state;
    nq = 0;
    if (m_state == 3) begin
      if (bus.fault_clear && ff == 0) ns = 0;
    end else if (m_state == 0) begin
      if (bus.enable) ns = (ff != 0) ? 3 : 1;
    end else if (ff != 0) begin
      ns = 3;
    end else if (!bus.enable) begin
      ns = 0;
    end else if (m_state == 1) begin
      if (wf != 0) ns = 2;
    end else begin
      if (wf != 0) nq = 0;
      else nq = m_quiet + 1;
      if (nq == REC) begin
        ns = 1;
        nq = 0;
      end
    end
    if (ns != 2) nq = 0;
    if (ns == 3 && m_state != 3 && m_fc < FMAX) m_fc = m_fc + 1;
    m_chg   = (ns != m_state) ? 1 : 0;
    m_state = ns;
    m_quiet = nq;
    debounce(m_w_s2, m_w_f, m_w_run);
    debounce(m_f_s2, m_f_f, m_f_run);
    m_w_s2 = m_w_s1;  m_w_s1 = int'(bus.warn_cond);
    m_f_s2 = m_f_s1;  m_f_s1 = int'(bus.fault_cond);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check("state", 32'(bus.system_state), m_state);
    check("changed", 32'(bus.state_changed), m_chg);
    check("fault_count", 32'(bus.fault_count), m_fc);
  endtask

  task automatic wait_fault(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (m_state == 3) break;
      tick();
    end
    check(tag, 32'(bus.system_state), 3);
  endtask

  int w_hold, f_hold;

  initial begin
    model_reset();
    reset = 1'b0;
    bus.enable = 1'b1; bus.warn_cond = 1'b1; bus.fault_cond = 1'b1; bus.fault_clear = 1'b1;

    // Reset with every input high.
    repeat (3) tick();
    check("rst_state", 32'(bus.system_state), 0);
    check("rst_changed", 32'(bus.state_changed), 0);
    check("rst_count", 32'(bus.fault_count), 0);

    // Release into NORMAL.
    @(negedge clk);
    bus.warn_cond = 1'b0; bus.fault_cond = 1'b0; bus.fault_clear = 1'b0;
    reset = 1'b1;
    tick();
    check("start_normal", 32'(bus.system_state), 1);
    check("start_pulse", 32'(bus.state_changed), 1);
    tick();
    check("start_pulse_end", 32'(bus.state_changed), 0);

    // Three-cycle glitch is swallowed.
    bus.warn_cond = 1'b1;
    repeat (3) tick();
    bus.warn_cond = 1'b0;
    repeat (8) tick();
    check("glitch_ignored", 32'(bus.system_state), 1);

    // Held warning reaches WARNING on the seventh edge after it was raised.
    bus.warn_cond = 1'b1;
    repeat (6) tick();
    check("warn_not_yet", 32'(bus.system_state), 1);
    tick();
    check("warn_entry", 32'(bus.system_state), 2);
    check("warn_pulse", 32'(bus.state_changed), 1);
    tick();
    check("warn_pulse_end", 32'(bus.state_changed), 0);

    // Interrupted recovery restarts; final recovery 16 edges after warn_f falls.
    bus.warn_cond = 1'b0;
    repeat (10) tick();
    bus.warn_cond = 1'b1;
    repeat (8) tick();
    bus.warn_cond = 1'b0;
    repeat (21) tick();
    check("recover_not_yet", 32'(bus.system_state), 2);
    tick();
    check("recovered", 32'(bus.system_state), 1);
    check("recover_pulse", 32'(bus.state_changed), 1);

    // Fault latch, ignored clear, then a valid clear.
    bus.fault_cond = 1'b1;
    repeat (6) tick();
    check("fault_not_yet", 32'(bus.system_state), 1);
    tick();
    check("fault_entry", 32'(bus.system_state), 3);
    check("fault_count1", 32'(bus.fault_count), 1);
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    check("clear_ignored", 32'(bus.system_state), 3);
    tick();
    check("clear_not_kept", 32'(bus.system_state), 3);
    bus.fault_cond = 1'b0;
    repeat (6) tick();
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    check("cleared_idle", 32'(bus.system_state), 0);
    check("cleared_pulse", 32'(bus.state_changed), 1);
    tick();
    check("idle_to_normal", 32'(bus.system_state), 1);

    // WARNING with enable low and fault_f rising on the same edge -> FAULT.
    bus.warn_cond = 1'b1;
    repeat (7) tick();
    check("prio_warning", 32'(bus.system_state), 2);
    bus.fault_cond = 1'b1;
    repeat (6) tick();
    bus.enable = 1'b0;
    tick();
    check("prio_fault", 32'(bus.system_state), 3);
    check("fault_count2", 32'(bus.fault_count), 2);
    bus.enable = 1'b1; bus.fault_cond = 1'b0; bus.warn_cond = 1'b0;
    repeat (6) tick();
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    tick();
    check("prio_back_normal", 32'(bus.system_state), 1);

    // NORMAL with enable low and warn_f high -> IDLE.
    bus.warn_cond = 1'b1;
    repeat (6) tick();
    bus.enable = 1'b0;
    tick();
    check("prio_idle", 32'(bus.system_state), 0);
    bus.warn_cond = 1'b0;
    bus.enable = 1'b1;

    // Randomized run-length stimulus checked every edge by the model.
    w_hold = 0;
    f_hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (w_hold == 0) begin
        bus.warn_cond = 1'($urandom_range(0, 1));
        w_hold = int'($urandom_range(1, 24));
      end
      if (f_hold == 0) begin
        bus.fault_cond = ($urandom_range(0, 3) == 0);
        f_hold = int'($urandom_range(1, 30));
      end
      w_hold--;
      f_hold--;
      bus.enable      = ($urandom_range(0, 15) != 0);
      bus.fault_clear = ($urandom_range(0, 5) == 0);
      tick();
    end

    // Saturate the fault-entry counter.
    bus.warn_cond = 1'b0; bus.fault_cond = 1'b0; bus.fault_clear = 1'b0; bus.enable = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 300; i++) begin
      bus.fault_cond = 1'b1;
      wait_fault("sat_enter");
      bus.fault_cond = 1'b0;
      repeat (6) tick();
      bus.fault_clear = 1'b1;
      tick();
      bus.fault_clear = 1'b0;
      tick();
    end
    check("sat_count", 32'(bus.fault_count), FMAX);

    // Asynchronous reset while latched in FAULT.
    bus.fault_cond = 1'b1;
    wait_fault("pre_reset_fault");
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_state", 32'(bus.system_state), 0);
    check("async_changed", 32'(bus.state_changed), 0);
    check("async_count", 32'(bus.fault_count), 0);
    repeat (2) tick();
    @(negedge clk);
    bus.fault_cond = 1'b0;
    reset = 1'b1;
    tick();
    check("post_reset_normal", 32'(bus.system_state), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_system_state_fsm
